// File: rtl/half_predict.sv
// rtl/half_predict.sv - binary16 two-layer MLP inference engine with shared MAC lanes
module hf_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] p
);
    logic              sign;
    logic [21:0]       prod;
    logic [9:0]        frac;
    logic              grd;
    logic              stk;
    logic              up;
    logic [10:0]       frac_r;
    logic signed [7:0] e;

    always_comb begin
        sign = a[15] ^ b[15];
        prod = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        e    = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
        if (prod[21]) begin
            frac = prod[20:11];
            grd  = prod[10];
            stk  = |prod[9:0];
            e    = e + 8'sd1;
        end else begin
            frac = prod[19:10];
            grd  = prod[9];
            stk  = |prod[8:0];
        end
        up     = grd & (stk | frac[0]);
        frac_r = {1'b0, frac} + {10'b0, up};
        if (frac_r[10]) begin
            e = e + 8'sd1;
        end
        if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
            p = {sign, 15'b0};
        end else if (a[14:10] == 5'h1f || b[14:10] == 5'h1f) begin
            p = {sign, 5'h1f, 10'b0};
        end else if (e >= 8'sd31) begin
            p = {sign, 5'h1f, 10'b0};
        end else if (e <= 8'sd0) begin
            p = {sign, 15'b0};
        end else begin
            p = {sign, e[4:0], frac_r[9:0]};
        end
    end
endmodule

module hf_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);
    logic [15:0]       big;
    logic [15:0]       sml;
    logic [4:0]        d;
    logic [14:0]       mb;
    logic [14:0]       ms;
    logic [14:0]       ms_sh;
    logic [14:0]       sum;
    logic [13:0]       n;
    logic [3:0]        lz;
    logic              up;
    logic [10:0]       frac_r;
    logic signed [6:0] e;

    function automatic logic [3:0] lzc14(input logic [13:0] v);
        logic [3:0] c;
        c = 4'd14;
        for (int k = 0; k < 14; k++) begin
            if (v[k]) c = 4'(13 - k);
        end
        return c;
    endfunction

    always_comb begin
        if (a[14:0] >= b[14:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d  = big[14:10] - sml[14:10];
        mb = {2'b01, big[9:0], 3'b000};
        ms = {2'b01, sml[9:0], 3'b000};
        // Three extra bits below the mantissa carry guard/round/sticky through the alignment
        if (d >= 5'd15) begin
            ms_sh = 15'd1;
        end else begin
            ms_sh = (ms >> d) | {14'b0, |(ms & ~(15'h7fff << d))};
        end
        if (big[15] == sml[15]) begin
            sum = mb + ms_sh;
        end else begin
            sum = mb - ms_sh;
        end
        e  = $signed({2'b00, big[14:10]});
        lz = 4'd0;
        if (sum[14]) begin
            n = sum[14:1] | {13'b0, sum[0]};
            e = e + 7'sd1;
        end else begin
            lz = lzc14(sum[13:0]);
            n  = sum[13:0] << lz;
            e  = e - $signed({3'b000, lz});
        end
        up     = n[2] & ((|n[1:0]) | n[3]);
        frac_r = {1'b0, n[12:3]} + {10'b0, up};
        if (frac_r[10]) begin
            e = e + 7'sd1;
        end
        if (a[14:10] == 5'h1f) begin
            s = a;
        end else if (b[14:10] == 5'h1f) begin
            s = b;
        end else if (a[14:10] == 5'd0 && b[14:10] == 5'd0) begin
            s = {a[15] & b[15], 15'b0};
        end else if (a[14:10] == 5'd0) begin
            s = b;
        end else if (b[14:10] == 5'd0) begin
            s = a;
        end else if (!n[13]) begin
            s = 16'h0000;
        end else if (e >= 7'sd31) begin
            s = {big[15], 5'h1f, 10'b0};
        end else if (e <= 7'sd0) begin
            s = {big[15], 15'b0};
        end else begin
            s = {big[15], e[4:0], frac_r[9:0]};
        end
    end
endmodule

module half_predict #(
    parameter int LAYER1_NEURONS = 784,
    parameter int LAYER2_NEURONS = 50,
    parameter int OUTPUT_NODES   = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] x  [LAYER1_NEURONS],
    input  logic [15:0] W1 [LAYER1_NEURONS][LAYER2_NEURONS],
    input  logic [15:0] b1 [LAYER2_NEURONS],
    input  logic [15:0] W2 [LAYER2_NEURONS][OUTPUT_NODES],
    input  logic [15:0] b2 [OUTPUT_NODES],
    output logic        done,
    output logic [15:0] y  [OUTPUT_NODES]
);
    localparam int IW = (LAYER1_NEURONS > 1) ? $clog2(LAYER1_NEURONS) : 1;
    localparam int JW = (LAYER2_NEURONS > 1) ? $clog2(LAYER2_NEURONS) : 1;
    localparam logic [IW-1:0] I_LAST = IW'(LAYER1_NEURONS - 1);
    localparam logic [JW-1:0] J_LAST = JW'(LAYER2_NEURONS - 1);

    typedef enum logic [2:0] {S_IDLE, S_L1, S_ACT, S_L2, S_FIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic          load_en;
    logic          mac1_en;
    logic          act_en;
    logic          mac2_en;
    logic          fin_en;
    logic [IW-1:0] i_cnt;
    logic [JW-1:0] j_cnt;
    logic [15:0]   acc1 [LAYER2_NEURONS];
    logic [15:0]   h    [LAYER2_NEURONS];
    logic [15:0]   acc2 [OUTPUT_NODES];
    logic [15:0]   sum  [LAYER2_NEURONS];

    function automatic logic [15:0] quarter(input logic [15:0] v);
        if (v[14:10] <= 5'd2) return {v[15], 15'b0};
        if (v[14:10] == 5'h1f) return v;
        return {v[15], v[14:10] - 5'd2, v[9:0]};
    endfunction

    function automatic logic [15:0] hard_clamp(input logic [15:0] v);
        if (v[15]) return 16'h0000;
        if (v[14:0] > 15'h3C00) return 16'h3C00;
        return v;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_L1;
            S_L1:    if (i_cnt == I_LAST) state_nxt = S_ACT;
            S_ACT:   state_nxt = S_L2;
            S_L2:    if (j_cnt == J_LAST) state_nxt = S_FIN;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        load_en = (state == S_IDLE) && start;
        mac1_en = (state == S_L1);
        act_en  = (state == S_ACT);
        mac2_en = (state == S_L2);
        fin_en  = (state == S_FIN);
    end

    // The first OUTPUT_NODES lanes double as the layer-2 MACs and all lanes do the ACT add
    for (genvar g = 0; g < LAYER2_NEURONS; g++) begin : g_lane
        logic [15:0] mul_a;
        logic [15:0] mul_b;
        logic [15:0] add_a;
        logic [15:0] add_b;
        logic [15:0] prod;

        if (g < OUTPUT_NODES) begin : g_shared
            always_comb begin
                mul_a = x[i_cnt];
                mul_b = W1[i_cnt][g];
                add_a = acc1[g];
                add_b = prod;
                if (act_en) begin
                    add_a = quarter(acc1[g]);
                    add_b = 16'h3800;
                end else if (mac2_en) begin
                    mul_a = h[j_cnt];
                    mul_b = W2[j_cnt][g];
                    add_a = acc2[g];
                end
            end
        end else begin : g_hidden
            always_comb begin
                mul_a = x[i_cnt];
                mul_b = W1[i_cnt][g];
                add_a = acc1[g];
                add_b = prod;
                if (act_en) begin
                    add_a = quarter(acc1[g]);
                    add_b = 16'h3800;
                end
            end
        end

        hf_mul u_mul (.a(mul_a), .b(mul_b), .p(prod));
        hf_add u_add (.a(add_a), .b(add_b), .s(sum[g]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_cnt <= '0;
            j_cnt <= '0;
            done  <= 1'b0;
            for (int n = 0; n < LAYER2_NEURONS; n++) begin
                acc1[n] <= 16'h0000;
                h[n]    <= 16'h0000;
            end
            for (int k = 0; k < OUTPUT_NODES; k++) begin
                acc2[k] <= 16'h0000;
                y[k]    <= 16'h0000;
            end
        end else begin
            if (load_en) begin
                done  <= 1'b0;
                i_cnt <= '0;
                for (int n = 0; n < LAYER2_NEURONS; n++) acc1[n] <= b1[n];
            end
            if (mac1_en) begin
                i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
                for (int n = 0; n < LAYER2_NEURONS; n++) acc1[n] <= sum[n];
            end
            if (act_en) begin
                j_cnt <= '0;
                for (int n = 0; n < LAYER2_NEURONS; n++) h[n] <= hard_clamp(sum[n]);
                for (int k = 0; k < OUTPUT_NODES; k++) acc2[k] <= b2[k];
            end
            if (mac2_en) begin
                j_cnt <= (j_cnt == J_LAST) ? '0 : j_cnt + 1'b1;
                for (int k = 0; k < OUTPUT_NODES; k++) acc2[k] <= sum[k];
            end
            if (fin_en) begin
                done <= 1'b1;
                for (int k = 0; k < OUTPUT_NODES; k++) y[k] <= acc2[k];
            end
        end
    end
endmodule

// File: tb/tb_half_predict.sv
// tb/tb_half_predict.sv - directed checks of half_predict latency, bias, clamp and reset behaviour
module tb_half_predict;
    localparam int N1 = 784;
    localparam int N2 = 50;
    localparam int NO = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x  [N1];
    logic [15:0] W1 [N1][N2];
    logic [15:0] b1 [N2];
    logic [15:0] W2 [N2][NO];
    logic [15:0] b2 [NO];
    logic        done;
    logic [15:0] y  [NO];
    logic [15:0] bias_tab [NO];

    int checks   = 0;
    int failures = 0;
    int lat;

    half_predict #(
        .LAYER1_NEURONS(N1),
        .LAYER2_NEURONS(N2),
        .OUTPUT_NODES  (NO)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .x    (x),
        .W1   (W1),
        .b1   (b1),
        .W2   (W2),
        .b2   (b2),
        .done (done),
        .y    (y)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_net();
        for (int i = 0; i < N1; i++) begin
            x[i] = 16'h0000;
            for (int j = 0; j < N2; j++) W1[i][j] = 16'h0000;
        end
        for (int j = 0; j < N2; j++) begin
            b1[j] = 16'h0000;
            for (int k = 0; k < NO; k++) W2[j][k] = 16'h0000;
        end
        for (int k = 0; k < NO; k++) b2[k] = 16'h0000;
    endtask

    // start stays high for `hold` edges; lat counts edges after the accepting edge until done
    task automatic run_net(input int hold, output int lat_o);
        int cnt;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (hold <= 1) start = 1'b0;
        check_eq("done_clr", {31'b0, done}, 32'd0);
        cnt = 0;
        while (done !== 1'b1 && cnt < 2000) begin
            @(posedge clk);
            #1;
            cnt++;
            if (cnt >= hold - 1) start = 1'b0;
        end
        start = 1'b0;
        if (cnt >= 2000) check_eq("done_timeout", {31'b0, done}, 32'd1);
        lat_o = cnt;
    endtask

    initial begin
        bias_tab = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                     16'h4500, 16'h4600, 16'h4700, 16'h4800, 16'h4880};
        rst   = 1'b1;
        start = 1'b0;
        clear_net();

        repeat (10) @(posedge clk);
        #1;
        check_eq("rst_done", {31'b0, done}, 32'd0);
        for (int k = 0; k < NO; k++) check_eq($sformatf("rst_y%0d", k), {16'b0, y[k]}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        run_net(1, lat);
        check_eq("zero_lat", lat, 32'd836);
        check_eq("zero_y0", {16'b0, y[0]}, 32'h0000);
        check_eq("zero_y9", {16'b0, y[9]}, 32'h0000);

        for (int k = 0; k < NO; k++) b2[k] = bias_tab[k];
        run_net(1, lat);
        for (int k = 0; k < NO; k++) check_eq($sformatf("bias_y%0d", k), {16'b0, y[k]}, {16'b0, bias_tab[k]});

        clear_net();
        for (int i = 0; i < N1; i++) begin
            x[i]     = 16'h3C00;
            W1[i][0] = 16'h3C00;
        end
        W2[0][0] = 16'h3C00;
        run_net(1, lat);
        check_eq("clamp_hi_y0", {16'b0, y[0]}, 32'h3C00);
        check_eq("clamp_hi_y1", {16'b0, y[1]}, 32'h0000);

        for (int i = 0; i < N1; i++) W1[i][0] = 16'hBC00;
        run_net(1, lat);
        check_eq("clamp_lo_y0", {16'b0, y[0]}, 32'h0000);
        check_eq("clamp_lo_y1", {16'b0, y[1]}, 32'h0000);

        // acc1[0]=1.0 -> h0=0.75; h1=h2=0.5
        clear_net();
        for (int i = 0; i < N1; i++) x[i] = 16'h3C00;
        W1[0][0] = 16'h3C00;
        W2[0][0] = 16'h4000;
        W2[0][1] = 16'h3C00;
        W2[1][1] = 16'h3C00;
        W2[2][2] = 16'h3C00;
        b2[2]    = 16'hBC00;
        run_net(1, lat);
        check_eq("lin_y0", {16'b0, y[0]}, 32'h3E00);
        check_eq("lin_y1", {16'b0, y[1]}, 32'h3D00);
        check_eq("lin_y2", {16'b0, y[2]}, 32'hB800);
        check_eq("lin_y3", {16'b0, y[3]}, 32'h0000);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (399) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_eq("abort_done", {31'b0, done}, 32'd0);
        check_eq("abort_y0", {16'b0, y[0]}, 32'h0000);
        check_eq("abort_y1", {16'b0, y[1]}, 32'h0000);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (900) @(posedge clk);
        #1;
        check_eq("abort_idle_done", {31'b0, done}, 32'd0);

        run_net(1, lat);
        check_eq("restart_lat", lat, 32'd836);
        check_eq("restart_y0", {16'b0, y[0]}, 32'h3E00);
        check_eq("restart_y2", {16'b0, y[2]}, 32'hB800);

        clear_net();
        for (int k = 0; k < NO; k++) b2[k] = bias_tab[k];
        run_net(5, lat);
        check_eq("held_lat", lat, 32'd836);
        check_eq("held_y9", {16'b0, y[9]}, 32'h4880);
        repeat (5) @(posedge clk);
        #1;
        check_eq("hold_done", {31'b0, done}, 32'd1);
        check_eq("hold_y3", {16'b0, y[3]}, 32'h4200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
